// File: rtl/cpu_pkg.sv
// Shared widths, register-zero ID and forwarding-source encoding for the operand stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int DATA_W   = 16;
    localparam int REG_ID_W = 4;
    localparam int CTRL_W   = 8;

    localparam logic [REG_ID_W-1:0] REG_ZERO = '0;

    // Which source supplied a resolved operand; ordered lowest to highest priority.
    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_EX  = 2'd3
    } fwd_sel_e;

endpackage

// File: rtl/operand_fwd_mux.sv
// Resolves one source operand: register 0, then EX > MEM > WB bypass, else register-file data.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   reg_id_i                          source register ID being read
//   ex_*_i / mem_*_i / wb_*_i         writer tuple of each downstream stage
//   rf_dat_i                          register-file read data for reg_id_i
//   val_o                             resolved operand
//   sel_o                             source that won (debug visibility)
module operand_fwd_mux
    import cpu_pkg::*;
#(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int REG_ID_W = cpu_pkg::REG_ID_W
) (
    input  logic [REG_ID_W-1:0] reg_id_i,
    input  logic                ex_vld_i,
    input  logic                ex_wr_i,
    input  logic [REG_ID_W-1:0] ex_rd_i,
    input  logic [DATA_W-1:0]   ex_dat_i,
    input  logic                mem_vld_i,
    input  logic                mem_wr_i,
    input  logic [REG_ID_W-1:0] mem_rd_i,
    input  logic [DATA_W-1:0]   mem_dat_i,
    input  logic                wb_wr_i,
    input  logic [REG_ID_W-1:0] wb_rd_i,
    input  logic [DATA_W-1:0]   wb_dat_i,
    input  logic [DATA_W-1:0]   rf_dat_i,
    output logic [DATA_W-1:0]   val_o,
    output fwd_sel_e            sel_o
);

    always_comb begin
        val_o = rf_dat_i;
        sel_o = FWD_RF;
        // Register 0 reads as zero even if some stage claims to write it,
        // so a stray write to r0 can never leak through a bypass path.
        if (reg_id_i == REG_ZERO) begin
            val_o = '0;
            sel_o = FWD_RF;
        end else if (ex_vld_i && ex_wr_i && (ex_rd_i == reg_id_i)) begin
            val_o = ex_dat_i;
            sel_o = FWD_EX;
        end else if (mem_vld_i && mem_wr_i && (mem_rd_i == reg_id_i)) begin
            val_o = mem_dat_i;
            sel_o = FWD_MEM;
        end else if (wb_wr_i && (wb_rd_i == reg_id_i)) begin
            // Register file has no internal write-through; this covers the
            // write and read landing in the same cycle.
            val_o = wb_dat_i;
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: resolves rs/rt with forwarding, detects load-use, registers into ID/EX.
// Latency: one cycle from ID inputs to ex_* outputs; stall_id is combinational.
// Backpressure: ex_hold freezes ID/EX and stalls IF/ID; load-use inserts one bubble; flush overrides both.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_*                     decoded instruction in ID
//   rf_data1/2               register-file read data for id_rs/id_rt
//   alu_result               EX result of the instruction currently held in ID/EX
//   mem_*, wb_*              downstream writer information for bypassing
//   flush, ex_hold           squash / freeze requests from later stages
//   stall_id                 hold PC and IF/ID this cycle
//   ex_*                     ID/EX pipeline register contents
//   lu_stall_cnt             saturating count of load-use bubbles
//   dbg_fwd_sel1/2           forwarding source chosen for rs/rt this cycle
module id_ex_operand_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int REG_ID_W = cpu_pkg::REG_ID_W,
    parameter int CTRL_W   = cpu_pkg::CTRL_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [REG_ID_W-1:0] id_rs,
    input  logic [REG_ID_W-1:0] id_rt,
    input  logic [REG_ID_W-1:0] id_rd,
    input  logic                id_uses_rs,
    input  logic                id_uses_rt,
    input  logic                id_reg_write,
    input  logic                id_mem_read,
    input  logic [DATA_W-1:0]   id_imm,
    input  logic [CTRL_W-1:0]   id_ctrl,
    input  logic [DATA_W-1:0]   rf_data1,
    input  logic [DATA_W-1:0]   rf_data2,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic                mem_valid,
    input  logic                mem_reg_write,
    input  logic [REG_ID_W-1:0] mem_rd,
    input  logic [DATA_W-1:0]   mem_data,
    input  logic                wb_reg_write,
    input  logic [REG_ID_W-1:0] wb_rd,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic                flush,
    input  logic                ex_hold,
    output logic                stall_id,
    output logic                ex_valid,
    output logic                ex_reg_write,
    output logic                ex_mem_read,
    output logic [DATA_W-1:0]   ex_op1,
    output logic [DATA_W-1:0]   ex_op2,
    output logic [DATA_W-1:0]   ex_imm,
    output logic [REG_ID_W-1:0] ex_rd,
    output logic [CTRL_W-1:0]   ex_ctrl,
    output logic [15:0]         lu_stall_cnt,
    output fwd_sel_e            dbg_fwd_sel1,
    output fwd_sel_e            dbg_fwd_sel2
);

    logic                ex_valid_q,     ex_valid_d;
    logic                ex_reg_write_q, ex_reg_write_d;
    logic                ex_mem_read_q,  ex_mem_read_d;
    logic [DATA_W-1:0]   ex_op1_q,       ex_op1_d;
    logic [DATA_W-1:0]   ex_op2_q,       ex_op2_d;
    logic [DATA_W-1:0]   ex_imm_q,       ex_imm_d;
    logic [REG_ID_W-1:0] ex_rd_q,        ex_rd_d;
    logic [CTRL_W-1:0]   ex_ctrl_q,      ex_ctrl_d;
    logic [15:0]         lu_stall_cnt_q, lu_stall_cnt_d;

    logic [DATA_W-1:0]   op1_res;
    logic [DATA_W-1:0]   op2_res;
    logic                lu;

    operand_fwd_mux #(
        .DATA_W   (DATA_W),
        .REG_ID_W (REG_ID_W)
    ) u_fwd_rs (
        .reg_id_i  (id_rs),
        .ex_vld_i  (ex_valid_q),
        .ex_wr_i   (ex_reg_write_q),
        .ex_rd_i   (ex_rd_q),
        .ex_dat_i  (alu_result),
        .mem_vld_i (mem_valid),
        .mem_wr_i  (mem_reg_write),
        .mem_rd_i  (mem_rd),
        .mem_dat_i (mem_data),
        .wb_wr_i   (wb_reg_write),
        .wb_rd_i   (wb_rd),
        .wb_dat_i  (wb_data),
        .rf_dat_i  (rf_data1),
        .val_o     (op1_res),
        .sel_o     (dbg_fwd_sel1)
    );

    operand_fwd_mux #(
        .DATA_W   (DATA_W),
        .REG_ID_W (REG_ID_W)
    ) u_fwd_rt (
        .reg_id_i  (id_rt),
        .ex_vld_i  (ex_valid_q),
        .ex_wr_i   (ex_reg_write_q),
        .ex_rd_i   (ex_rd_q),
        .ex_dat_i  (alu_result),
        .mem_vld_i (mem_valid),
        .mem_wr_i  (mem_reg_write),
        .mem_rd_i  (mem_rd),
        .mem_dat_i (mem_data),
        .wb_wr_i   (wb_reg_write),
        .wb_rd_i   (wb_rd),
        .wb_dat_i  (wb_data),
        .rf_dat_i  (rf_data2),
        .val_o     (op2_res),
        .sel_o     (dbg_fwd_sel2)
    );

    // A load in EX only has its data one stage later, so a dependent reader
    // in ID must wait exactly one cycle and then pick it up from MEM.
    // Loads targeting r0 produce nothing to wait for.
    assign lu = id_valid && ex_valid_q && ex_mem_read_q && (ex_rd_q != REG_ZERO) &&
                ((id_uses_rs && (ex_rd_q == id_rs)) || (id_uses_rt && (ex_rd_q == id_rt)));

    // Flush squashes whatever is in ID anyway, so holding IF/ID would be pointless.
    assign stall_id = !rst && !flush && (ex_hold || lu);

    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_reg_write_d = ex_reg_write_q;
        ex_mem_read_d  = ex_mem_read_q;
        ex_op1_d       = ex_op1_q;
        ex_op2_d       = ex_op2_q;
        ex_imm_d       = ex_imm_q;
        ex_rd_d        = ex_rd_q;
        ex_ctrl_d      = ex_ctrl_q;
        lu_stall_cnt_d = lu_stall_cnt_q;

        if (flush) begin
            ex_valid_d     = 1'b0;
            ex_reg_write_d = 1'b0;
            ex_mem_read_d  = 1'b0;
            ex_op1_d       = '0;
            ex_op2_d       = '0;
            ex_imm_d       = '0;
            ex_rd_d        = '0;
            ex_ctrl_d      = '0;
        end else if (ex_hold) begin
            // Everything keeps its value; any hazard is re-checked once released.
        end else if (lu) begin
            ex_valid_d     = 1'b0;
            ex_reg_write_d = 1'b0;
            ex_mem_read_d  = 1'b0;
            ex_op1_d       = '0;
            ex_op2_d       = '0;
            ex_imm_d       = '0;
            ex_rd_d        = '0;
            ex_ctrl_d      = '0;
            if (lu_stall_cnt_q != 16'hFFFF) begin
                lu_stall_cnt_d = lu_stall_cnt_q + 16'd1;
            end
        end else begin
            ex_valid_d     = id_valid;
            ex_reg_write_d = id_valid && id_reg_write;
            ex_mem_read_d  = id_valid && id_mem_read;
            ex_op1_d       = op1_res;
            ex_op2_d       = op2_res;
            ex_imm_d       = id_imm;
            ex_rd_d        = id_rd;
            ex_ctrl_d      = id_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q     <= 1'b0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_op1_q       <= '0;
            ex_op2_q       <= '0;
            ex_imm_q       <= '0;
            ex_rd_q        <= '0;
            ex_ctrl_q      <= '0;
            lu_stall_cnt_q <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_reg_write_q <= ex_reg_write_d;
            ex_mem_read_q  <= ex_mem_read_d;
            ex_op1_q       <= ex_op1_d;
            ex_op2_q       <= ex_op2_d;
            ex_imm_q       <= ex_imm_d;
            ex_rd_q        <= ex_rd_d;
            ex_ctrl_q      <= ex_ctrl_d;
            lu_stall_cnt_q <= lu_stall_cnt_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_reg_write = ex_reg_write_q;
    assign ex_mem_read  = ex_mem_read_q;
    assign ex_op1       = ex_op1_q;
    assign ex_op2       = ex_op2_q;
    assign ex_imm       = ex_imm_q;
    assign ex_rd        = ex_rd_q;
    assign ex_ctrl      = ex_ctrl_q;
    assign lu_stall_cnt = lu_stall_cnt_q;

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Decode-to-execute operand stage, directly downstream of the register file.
- Consumes the two register-file read ports and resolves register 0 and bypass/forwarding from the EX, MEM and WB stages.
- Detects load-use hazards and registers the resolved operands and control into the ID/EX pipeline register.
- Drives the stall back to IF/ID and accepts flush and hold from later stages.

Parameters:
- DATA_W, 16: operand/data width.
- REG_ID_W, 4: register ID width (16 registers).
- CTRL_W, 8: opaque EX/MEM/WB control bundle width, passed through unmodified.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt, id_rd  in  REG_ID_W each  source and destination IDs; rs/rt also drive the register-file read ports.
- id_uses_rs, id_uses_rt  in  1 each  operand is actually read (hazard qualification).
- id_reg_write, id_mem_read  in  1 each  instruction writes rd / is a load.
- id_imm  in  DATA_W  sign-extended immediate.
- id_ctrl  in  CTRL_W  control bundle.
- rf_data1, rf_data2  in  DATA_W  register-file read data for rs/rt.
- alu_result  in  DATA_W  combinational EX result of the instruction held in ID/EX.
- mem_valid, mem_reg_write  in  1  MEM-stage writer info.
- mem_rd  in  REG_ID_W  MEM-stage destination.
- mem_data  in  DATA_W  MEM result; load data for loads.
- wb_reg_write  in  1  same signal as the register-file write enable.
- wb_rd  in  REG_ID_W  same as the register-file destination.
- wb_data  in  DATA_W  same as the register-file write data.
- flush  in  1  squash the instruction entering EX.
- ex_hold  in  1  downstream stall; freeze ID/EX.
- stall_id  out  1  hold PC and IF/ID this cycle (combinational).
- ex_valid, ex_reg_write, ex_mem_read  out  1  registered.
- ex_op1, ex_op2, ex_imm  out  DATA_W  registered resolved operands.
- ex_rd  out  REG_ID_W  registered.
- ex_ctrl  out  CTRL_W  registered.
- lu_stall_cnt  out  16  saturating load-use bubble counter.

Behaviour:
- Reset (rst=1 at a clk edge): every registered output goes to 0, including lu_stall_cnt. While rst=1, stall_id=0. A reset mid-stall discards the held instruction.
- Operand resolution (combinational; op1 shown, op2 identical with rt):
  - id_rs==0 gives 0 regardless of any source.
  - Otherwise the first match wins:
    1. EX: ex_valid & ex_reg_write & ex_rd==id_rs, value alu_result.
    2. MEM: mem_valid & mem_reg_write & mem_rd==id_rs, value mem_data.
    3. WB: wb_reg_write & wb_rd==id_rs, value wb_data. This is the same-cycle write/read bypass; the register file has none.
    4. rf_data1.
- Load-use hazard (lu):
  - Condition: id_valid & ex_valid & ex_mem_read & ex_rd!=0 & ((id_uses_rs & ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt)).
- stall_id = ~rst & ~flush & (ex_hold | lu).
- Pipeline register update per edge, in priority order:
  1. rst: clear.
  2. flush: load a bubble (ex_valid, ex_reg_write, ex_mem_read = 0; other fields don't-care, driven 0).
  3. ex_hold: hold all fields.
  4. lu: load a bubble and increment lu_stall_cnt.
  5. Otherwise: load resolved operands, id_imm, id_rd, id_ctrl. Set ex_valid=id_valid and gate ex_reg_write/ex_mem_read with id_valid.
- Latency: one cycle, ID to EX outputs.
- A load-use stall lasts exactly one cycle; the next cycle takes the load data via the MEM forward.
- lu_stall_cnt saturates at 16'hFFFF and does not wrap. No increment on hold or flush cycles.
- Simultaneous cases:
  - flush together with lu or hold: flush wins; stall_id=0 and no count.
  - hold together with lu: hold wins; stall_id=1 and no count. The hazard is re-evaluated after the hold releases.
- Writes to register 0 are never forwarded, whatever the stage flags.

Decomposition:
- Shared package cpu_pkg: DATA_W, REG_ID_W, CTRL_W, REG_ZERO=0, forward-select enum {FWD_RF, FWD_WB, FWD_MEM, FWD_EX}.
- One sub-module, operand_fwd_mux, instantiated twice (rs, rt). It takes the reg ID and the three stage tuples plus rf data and returns the value and the fwd select; the select is exposed for debug.
- Hazard logic, pipeline register and counter stay in the top level.

Test Plan:
- Reset then idle: after rst, all outputs 0. Then id_rs=3, rf_data1=16'h1234, no writers: next cycle ex_op1=16'h1234, ex_valid=1.
- Priority: id_rs=5 with ex_rd=mem_rd=wb_rd=5, all writing; alu_result=16'hAAAA, mem_data=16'hBBBB, wb_data=16'hCCCC -> ex_op1=16'hAAAA. Drop the EX writer -> 16'hBBBB. Drop MEM -> 16'hCCCC.
- Register 0: id_rt=0, wb_rd=0, wb_reg_write=1, wb_data=16'hFFFF, rf_data2=16'h0001 -> ex_op2=16'h0000.
- Load-use: ex holds a load with ex_rd=4, id_rs=4, id_uses_rs=1:
  - this cycle: stall_id=1, next ex_valid=0, lu_stall_cnt=1;
  - following cycle: mem_rd=4, mem_data=16'h00FF -> stall_id=0, ex_op1=16'h00FF.
- Hold vs lu vs flush:
  - ex_hold=1 with lu present -> ID/EX unchanged, count unchanged, stall_id=1.
  - flush=1 with lu -> bubble, stall_id=0, count unchanged.
- Saturation/reset: preload the counter to 16'hFFFE via 2 forced lu cycles from a forced state -> reads 16'hFFFF and stays. rst asserted mid-stall -> counter 0, ex_valid=0 on the next edge.
